// File: rtl/ntt_input_loader_if.sv
// Coefficient stream and ntt_core write-port bundle for the NTT input loader.
// The master side feeds coefficients and observes writes; the slave side is the loader.
interface ntt_input_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [29:0] s_data;
  logic        s_last;
  logic        write_enable;
  logic [8:0]  upper_write_address;
  logic [29:0] upper_data_input;
  logic [8:0]  lower_write_address;
  logic [29:0] lower_data_input;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, write_enable,
    input  upper_write_address, upper_data_input,
    input  lower_write_address, lower_data_input
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, write_enable,
    output upper_write_address, upper_data_input,
    output lower_write_address, lower_data_input
  );
endinterface

// File: rtl/ntt_input_loader.sv
// Loads 1024 natural-order coefficients into ntt_core, reducing each mod Q and
// writing even/odd pairs to both banks at the bit-reversed pair index.
module ntt_input_loader #(
  parameter logic [29:0] Q = 30'd1068564481
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 core_busy,
  ntt_input_loader_if.slave    bus,
  output logic                 loading,
  output logic                 done,
  output logic                 err
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state;
  state_t      state_next;
  logic [9:0]  k;
  logic [29:0] pair_q;
  logic        done_pending;
  logic        accept;
  logic [29:0] reduced;

  function automatic logic [8:0] bitrev9(input logic [8:0] v);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) begin
      r[i] = v[8 - i];
    end
    return r;
  endfunction

  assign bus.s_ready = (state == LOAD) && !core_busy;
  assign accept      = bus.s_valid && bus.s_ready;
  assign loading     = (state == LOAD);

  // Inputs are below 2^30 < 2Q, so one conditional subtract fully reduces them.
  assign reduced = (bus.s_data >= Q) ? (bus.s_data - Q) : bus.s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (accept && (bus.s_last || (k == 10'd1023))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // done trails the final write by one cycle through done_pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      k                       <= '0;
      pair_q                  <= '0;
      done_pending            <= 1'b0;
      done                    <= 1'b0;
      err                     <= 1'b0;
      bus.write_enable        <= 1'b0;
      bus.upper_write_address <= '0;
      bus.lower_write_address <= '0;
      bus.upper_data_input    <= '0;
      bus.lower_data_input    <= '0;
    end else begin
      bus.write_enable <= 1'b0;
      done_pending     <= 1'b0;
      done             <= done_pending;

      if ((state == IDLE) && start) begin
        k   <= '0;
        err <= 1'b0;
      end

      if (accept) begin
        k <= k + 10'd1;
        if (!k[0]) begin
          pair_q <= reduced;
        end else begin
          bus.write_enable        <= 1'b1;
          bus.upper_write_address <= bitrev9(k[9:1]);
          bus.lower_write_address <= bitrev9(k[9:1]);
          bus.upper_data_input    <= pair_q;
          bus.lower_data_input    <= reduced;
        end

        if (k == 10'd1023) begin
          done_pending <= 1'b1;
          if (!bus.s_last) begin
            err <= 1'b1;
          end
        end else if (bus.s_last) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntt_input_loader.sv
// Self-checking bench for ntt_input_loader: table vectors, directed corner loads
// and randomized loads checked against a pair/bit-reverse reference model.
module tb_ntt_input_loader;

  localparam logic [29:0] Q = 30'd1068564481;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic core_busy = 1'b0;
  logic loading;
  logic done;
  logic err;

  ntt_input_loader_if bus ();

  ntt_input_loader #(.Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .core_busy (core_busy),
    .bus       (bus),
    .loading   (loading),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [8:0]  ua;
    logic [8:0]  la;
    logic [29:0] ud;
    logic [29:0] ld;
  } wr_t;

  typedef struct {
    logic [29:0] ev;
    logic [29:0] od;
    logic [8:0]  addr;
    logic [29:0] up;
    logic [29:0] lo;
  } vec_t;

  wr_t         wr_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [29:0] coef[1024];
  int          acc_cyc[1024];
  int          n_acc;
  vec_t        vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe and done pulse is logged with its cycle number.
  always @(negedge clk) begin
    wr_t w;
    if (bus.write_enable) begin
      w.cyc = cyc;
      w.ua  = bus.upper_write_address;
      w.la  = bus.lower_write_address;
      w.ud  = bus.upper_data_input;
      w.ld  = bus.lower_data_input;
      wr_q.push_back(w);
    end
    if (done) done_q.push_back(cyc);
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rev9(input int v);
    int r = 0;
    int x = v;
    for (int b = 0; b < 9; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [29:0] red(input logic [29:0] x);
    return (x >= Q) ? (x - Q) : x;
  endfunction

  // Runs one load and compares every observed write/done/err against the model.
  task automatic apply_stimulus(input int n_send, input int last_idx, input int valid_pct,
                                input int busy_pct, input int stall_at, input int start_at,
                                input int reset_at);
    int  budget;
    bit  accepted;
    bit  stalling;
    int  stall_cnt;
    bit  was_reset;
    bit  exp_done;
    bit  exp_err;
    int  n_wr;
    int  n_chk;
    logic [8:0] a;
    wr_q.delete();
    done_q.delete();
    n_acc     = 0;
    was_reset = 1'b0;
    stall_cnt = 0;

    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    check_output("s_ready_on_start", bus.s_ready, 0);
    @(posedge clk); #1 start = 1'b0;
    check_output("err_cleared_by_start", err, 0);
    check_output("loading_after_start", loading, 1);

    for (int i = 0; i < n_send; i++) begin
      accepted = 1'b0;
      budget   = 0;
      while (!accepted && budget < 200) begin
        stalling = (i == stall_at) && (stall_cnt < 5);
        if (stalling) stall_cnt++;
        bus.s_valid = stalling || ($urandom_range(99) < valid_pct);
        bus.s_data  = coef[i];
        bus.s_last  = (i == last_idx);
        core_busy   = stalling || ($urandom_range(99) < busy_pct);
        start       = (i == start_at) && (budget == 0);
        @(negedge clk);
        if (stalling) check_output("s_ready_stalled", bus.s_ready, 0);
        accepted = bus.s_valid && bus.s_ready;
        if (accepted) begin
          acc_cyc[i] = cyc;
          n_acc++;
        end
        @(posedge clk); #1;
        budget++;
      end
      if (!accepted) begin
        tests++;
        fails++;
        $display("[TB] FAIL accept_timeout: index %0d not accepted, required within 200 cycles", i);
        break;
      end
      if (i == reset_at) begin
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        start       = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_write_enable", bus.write_enable, 0);
        check_output("rst_addr", {bus.upper_write_address, bus.lower_write_address}, 0);
        check_output("rst_data", {bus.upper_data_input, bus.lower_data_input}, 0);
        check_output("rst_flags", {loading, done, err, bus.s_ready}, 0);
        was_reset = 1'b1;
        break;
      end
    end

    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    core_busy   = 1'b0;
    start       = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    n_wr = n_acc / 2;
    check_output("write_count", wr_q.size(), n_wr);
    n_chk = (wr_q.size() < n_wr) ? wr_q.size() : n_wr;
    for (int j = 0; j < n_chk; j++) begin
      a = 9'(rev9(j));
      check_output("write_addr", {wr_q[j].ua, wr_q[j].la}, {a, a});
      check_output("write_data", {wr_q[j].ud, wr_q[j].ld}, {red(coef[2*j]), red(coef[2*j+1])});
      check_output("write_cycle", wr_q[j].cyc, acc_cyc[2*j+1] + 1);
    end

    exp_done = !was_reset && (n_acc == 1024);
    check_output("done_count", done_q.size(), exp_done ? 1 : 0);
    if (exp_done && done_q.size() == 1)
      check_output("done_cycle", done_q[0], acc_cyc[1023] + 2);

    exp_err = !was_reset && (last_idx != 1023);
    check_output("err_final", err, exp_err);
    check_output("loading_final", loading, 0);
  endtask

  task automatic check_ramp();
    check_output("ramp_writes", wr_q.size(), 512);
    if (wr_q.size() == 512) begin
      check_output("ramp_first_addr", {wr_q[0].ua, wr_q[0].la}, {9'd0, 9'd0});
      check_output("ramp_first_data", {wr_q[0].ud, wr_q[0].ld}, {30'd0, 30'd1});
      check_output("ramp_second_addr", {wr_q[1].ua, wr_q[1].la}, {9'd256, 9'd256});
      check_output("ramp_second_data", {wr_q[1].ud, wr_q[1].ld}, {30'd2, 30'd3});
      check_output("ramp_last_addr", {wr_q[511].ua, wr_q[511].la}, {9'd511, 9'd511});
      check_output("ramp_last_data", {wr_q[511].ud, wr_q[511].ld}, {30'd1022, 30'd1023});
      if (done_q.size() == 1)
        check_output("ramp_done_after_write", done_q[0], wr_q[511].cyc + 1);
    end
    check_output("ramp_err", err, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 1024; i++) coef[i] = 30'(i);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{Q,             Q + 30'd5,   9'd0,   30'd0,         30'd5};
    vecs[1] = '{30'h3FFFFFFF,  Q - 30'd1,   9'd256, 30'd5177342,   30'd1068564480};
    vecs[2] = '{30'd4,         30'd5,       9'd128, 30'd4,         30'd5};
    vecs[3] = '{30'd0,         30'h3FFFFFFF, 9'd384, 30'd0,        30'd5177342};
    vecs[4] = '{Q + 30'd1,     Q - 30'd2,   9'd64,  30'd1,         30'd1068564479};
    vecs[5] = '{30'd536870912, Q + 30'd100, 9'd320, 30'd536870912, 30'd100};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_write_enable", bus.write_enable, 0);
    check_output("reset_flags", {loading, done, err, bus.s_ready}, 0);
    check_output("reset_addr", {bus.upper_write_address, bus.lower_write_address}, 0);

    fill_ramp();
    apply_stimulus(1024, 1023, 100, 0, -1, -1, -1);
    check_ramp();

    fill_ramp();
    for (int i = 0; i < 6; i++) begin
      coef[2*i]   = vecs[i].ev;
      coef[2*i+1] = vecs[i].od;
    end
    apply_stimulus(1024, 1023, 80, 0, -1, -1, -1);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_q.size()) begin
        check_output("vec_addr", {wr_q[i].ua, wr_q[i].la}, {vecs[i].addr, vecs[i].addr});
        check_output("vec_data", {wr_q[i].ud, wr_q[i].ld}, {vecs[i].up, vecs[i].lo});
      end
    end

    // Early s_last on an odd index still writes its pair.
    fill_ramp();
    apply_stimulus(10, 9, 100, 0, -1, -1, -1);
    check_output("early_last_writes", wr_q.size(), 5);
    if (wr_q.size() == 5)
      check_output("early_last_pair", {wr_q[4].ua, wr_q[4].ud, wr_q[4].ld}, {9'd64, 30'd8, 30'd9});

    apply_stimulus(7, 6, 100, 0, -1, -1, -1);

    apply_stimulus(1024, 1023, 100, 0, 300, -1, -1);
    check_ramp();

    apply_stimulus(1024, 1023, 100, 0, -1, -1, 500);
    check_output("reset_abort_writes", wr_q.size(), 250);
    apply_stimulus(1024, 1023, 100, 0, -1, -1, -1);
    check_ramp();

    apply_stimulus(1024, 1023, 100, 0, -1, 100, -1);
    check_ramp();

    apply_stimulus(1024, -1, 100, 0, -1, -1, -1);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 1024; i++) coef[i] = 30'($urandom);
      apply_stimulus(1024, 1023, 70, 25, -1, -1, -1);
    end
    for (int i = 0; i < 1024; i++) coef[i] = 30'($urandom);
    begin
      int li;
      li = int'($urandom_range(1022, 1));
      apply_stimulus(li + 1, li, 75, 20, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
